// File: rtl/conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_sequencer
//  Brief    : Steps a KxK filter window over an IMG_W x IMG_H image, issuing
//             one MAC tap per cycle and one result write per output pixel.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_sequencer #(
    parameter int IMG_W = 4,
    parameter int IMG_H = 4,
    parameter int K     = 3,
    parameter int AW    = 4,
    parameter int RW    = 2
) (
    input  logic          clk,
    input  logic          rst,        // asynchronous, active low
    input  logic          start,
    input  logic          abort,
    input  logic          load_ack,
    input  logic          stall,
    output logic [1:0]    state,
    output logic          load_req,
    output logic          mac_en,
    output logic          mac_first,
    output logic [AW-1:0] data_idx,
    output logic [3:0]    flt_idx,
    output logic          res_we,
    output logic [RW-1:0] res_addr,
    output logic          busy,
    output logic          done
);

    localparam int c_OUT_W = IMG_W - K + 1;
    localparam int c_OUT_H = IMG_H - K + 1;
    localparam int c_KW    = (K > 1)       ? $clog2(K)       : 1;
    localparam int c_XW    = (c_OUT_W > 1) ? $clog2(c_OUT_W) : 1;
    localparam int c_YW    = (c_OUT_H > 1) ? $clog2(c_OUT_H) : 1;

    localparam logic [c_KW-1:0] c_KMAX = c_KW'(K - 1);
    localparam logic [c_XW-1:0] c_XMAX = c_XW'(c_OUT_W - 1);
    localparam logic [c_YW-1:0] c_YMAX = c_YW'(c_OUT_H - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_WRITE   = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_KW-1:0] r_kx, r_ky, w_kx_nxt, w_ky_nxt;
    logic [c_XW-1:0] r_ox, w_ox_nxt;
    logic [c_YW-1:0] r_oy, w_oy_nxt;
    logic            r_done, w_done_nxt;

    logic [AW-1:0]   w_row;
    logic [AW-1:0]   w_col;

    // State, window/tap counters and the done pulse register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_kx    <= '0;
            r_ky    <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kx    <= w_kx_nxt;
            r_ky    <= w_ky_nxt;
            r_ox    <= w_ox_nxt;
            r_oy    <= w_oy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and counter stepping; abort always returns to IDLE with
    // counters cleared so the next pass starts at window 0 / tap 0
    always_comb begin
        w_state_nxt = r_state;
        w_kx_nxt    = r_kx;
        w_ky_nxt    = r_ky;
        w_ox_nxt    = r_ox;
        w_oy_nxt    = r_oy;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_LOAD;
                    w_kx_nxt    = '0;
                    w_ky_nxt    = '0;
                    w_ox_nxt    = '0;
                    w_oy_nxt    = '0;
                end
            end
            S_LOAD: begin
                if (load_ack) begin
                    w_state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (!stall) begin
                    if (r_kx == c_KMAX) begin
                        w_kx_nxt = '0;
                        if (r_ky == c_KMAX) begin
                            w_ky_nxt    = '0;
                            w_state_nxt = S_WRITE;
                        end else begin
                            w_ky_nxt = r_ky + c_KW'(1);
                        end
                    end else begin
                        w_kx_nxt = r_kx + c_KW'(1);
                    end
                end
            end
            S_WRITE: begin
                w_state_nxt = S_COMPUTE;
                if (r_ox == c_XMAX) begin
                    w_ox_nxt = '0;
                    if (r_oy == c_YMAX) begin
                        w_oy_nxt    = '0;
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_oy_nxt = r_oy + c_YW'(1);
                    end
                end else begin
                    w_ox_nxt = r_ox + c_XW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_kx_nxt    = '0;
            w_ky_nxt    = '0;
            w_ox_nxt    = '0;
            w_oy_nxt    = '0;
            w_done_nxt  = 1'b0;
        end
    end

    // Index decode: counters sit at zero outside a pass, so the indices
    // read zero in IDLE without extra gating
    assign w_row    = AW'(r_oy) + AW'(r_ky);
    assign w_col    = AW'(r_ox) + AW'(r_kx);
    assign data_idx = w_row * AW'(IMG_W) + w_col;
    assign flt_idx  = 4'(r_ky) * 4'(K) + 4'(r_kx);
    assign res_addr = RW'(r_oy) * RW'(c_OUT_W) + RW'(r_ox);

    assign state     = r_state;
    assign load_req  = (r_state == S_LOAD);
    // The tap strobe is the one output gated by an input: a stalled datapath
    // must see mac_en drop in the same cycle the counters freeze
    assign mac_en    = (r_state == S_COMPUTE) && !stall;
    assign mac_first = mac_en && (r_kx == '0) && (r_ky == '0);
    assign res_we    = (r_state == S_WRITE);
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire
